// File: rtl/tree_mac_accumulator_if.sv
// Data path between the tree MAC core, the K-tile accumulator and writeback.
// The MAC core side drives the partial sum, and the writeback side drains the result FIFO.
interface tree_mac_accumulator_if #(
    parameter int DATA_WIDTH      = 8,
    parameter int ADDRESS_WIDTH_I = 8,
    parameter int ADDRESS_WIDTH_K = 8
) ();
    logic [DATA_WIDTH-1:0]      sum_in;
    logic [ADDRESS_WIDTH_I-1:0] addr_i_in;
    logic [ADDRESS_WIDTH_K-1:0] addr_k_in;
    logic                       val_in;
    logic [DATA_WIDTH-1:0]      out_data;
    logic [ADDRESS_WIDTH_I-1:0] out_addr_i;
    logic                       out_val;
    logic                       out_rdy;

    modport master (
        output sum_in, addr_i_in, addr_k_in, val_in, out_rdy,
        input  out_data, out_addr_i, out_val
    );

    modport slave (
        input  sum_in, addr_i_in, addr_k_in, val_in, out_rdy,
        output out_data, out_addr_i, out_val
    );
endinterface

// File: rtl/tree_mac_accumulator.sv
// Accumulates the K-tile partial sums for each output row. Finished rows go into a small
// output FIFO, and the block raises sticky flags for dropped results and illegal K indices.
module tree_mac_accumulator #(
    parameter int DATA_WIDTH      = 8,
    parameter int ADDRESS_WIDTH_I = 8,
    parameter int ADDRESS_WIDTH_K = 8,
    parameter int NUM_K_TILES     = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int AFULL_MARGIN    = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    tree_mac_accumulator_if.slave         bus,
    output logic                          almost_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          err_overflow,
    output logic                          err_bad_k
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ACC_N = 2 ** ADDRESS_WIDTH_I;
    localparam logic [ADDRESS_WIDTH_K:0]   K_LIMIT = (ADDRESS_WIDTH_K + 1)'(NUM_K_TILES);
    localparam logic [ADDRESS_WIDTH_K-1:0] K_LAST  = ADDRESS_WIDTH_K'(NUM_K_TILES - 1);
    localparam logic [CNT_W-1:0]           DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0]                 acc_q  [ACC_N];
    logic [ADDRESS_WIDTH_I+DATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             afull_q, afull_d;
    logic             err_ovf_q, err_ovf_d;
    logic             err_bad_k_q, err_bad_k_d;

    logic                  k_ok, acc_we, push, pop, push_ok;
    logic [DATA_WIDTH-1:0] acc_new;

    always_comb begin
        k_ok     = {1'b0, bus.addr_k_in} < K_LIMIT;
        acc_we   = bus.val_in & k_ok;
        // k = 0 overwrites, so the accumulator array never needs a reset.
        acc_new  = (bus.addr_k_in == '0) ? bus.sum_in : acc_q[bus.addr_i_in] + bus.sum_in;
        push     = acc_we & (bus.addr_k_in == K_LAST);
        pop      = (count_q != '0) & bus.out_rdy;
        push_ok  = push & ((count_q < DEPTH_C) | pop);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
        else if (!push_ok && pop) count_d = count_q - CNT_W'(1);

        afull_d     = (32'(FIFO_DEPTH) - 32'(count_d)) <= 32'(AFULL_MARGIN);
        err_ovf_d   = err_ovf_q | (push & ~push_ok);
        err_bad_k_d = err_bad_k_q | (bus.val_in & ~k_ok);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            afull_q     <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_bad_k_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            afull_q     <= afull_d;
            err_ovf_q   <= err_ovf_d;
            err_bad_k_q <= err_bad_k_d;
        end
    end

    // Storage arrays carry no reset; the pointers and the count define which entries are valid.
    always_ff @(posedge clk) begin
        if (acc_we)  acc_q[bus.addr_i_in] <= acc_new;
        if (push_ok) fifo_q[wr_ptr_q]     <= {bus.addr_i_in, acc_new};
    end

    always_comb begin
        bus.out_val    = count_q != '0;
        bus.out_data   = fifo_q[rd_ptr_q][DATA_WIDTH-1:0];
        bus.out_addr_i = fifo_q[rd_ptr_q][DATA_WIDTH +: ADDRESS_WIDTH_I];
        fifo_count     = count_q;
        almost_full    = afull_q;
        err_overflow   = err_ovf_q;
        err_bad_k      = err_bad_k_q;
    end
endmodule

// File: tb/tb_tree_mac_accumulator.sv
// Directed and random bench for tree_mac_accumulator, checked against a queue-based model of
// row accumulation and of the output FIFO.
module tb_tree_mac_accumulator;
    localparam int DW = 8, AWI = 8, AWK = 8, NK = 4, DEPTH = 4, MARGIN = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       almost_full;
    logic [2:0] fifo_count;
    logic       err_overflow, err_bad_k;

    tree_mac_accumulator_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH_I(AWI), .ADDRESS_WIDTH_K(AWK)) bus ();

    tree_mac_accumulator #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH_I(AWI), .ADDRESS_WIDTH_K(AWK),
        .NUM_K_TILES(NK), .FIFO_DEPTH(DEPTH), .AFULL_MARGIN(MARGIN)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .almost_full(almost_full), .fifo_count(fifo_count),
        .err_overflow(err_overflow), .err_bad_k(err_bad_k)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int acc_m [256];
    int q_addr [$];
    int q_data [$];
    bit m_ovf, m_bad;
    int nk [6];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int sz = q_addr.size();
        chk({tag, ":out_val"}, 32'(bus.out_val), 32'(sz != 0));
        chk({tag, ":fifo_count"}, 32'(fifo_count), 32'(sz));
        chk({tag, ":almost_full"}, 32'(almost_full), 32'((DEPTH - sz) <= MARGIN));
        chk({tag, ":err_overflow"}, 32'(err_overflow), 32'(m_ovf));
        chk({tag, ":err_bad_k"}, 32'(err_bad_k), 32'(m_bad));
        if (sz != 0) begin
            chk({tag, ":out_data"}, 32'(bus.out_data), 32'(q_data[0]));
            chk({tag, ":out_addr_i"}, 32'(bus.out_addr_i), 32'(q_addr[0]));
        end
    endtask

    // Reference behaviour for one clock edge, computed from the pre-edge state.
    task automatic model_edge(input bit v, input int i, input int k, input int s, input bit rdy);
        int sz = q_addr.size();
        bit pop = (sz > 0) && rdy;
        int nv;
        if (pop) begin
            void'(q_addr.pop_front());
            void'(q_data.pop_front());
        end
        if (v) begin
            if (k >= NK) m_bad = 1'b1;
            else begin
                nv = (k == 0) ? s : (acc_m[i] + s) % 256;
                acc_m[i] = nv;
                if (k == NK - 1) begin
                    if (sz < DEPTH || pop) begin
                        q_addr.push_back(i);
                        q_data.push_back(nv);
                    end else m_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic step(input string tag, input bit v, input int i, input int k, input int s, input bit rdy);
        bus.val_in    = v;
        bus.addr_i_in = 8'(i);
        bus.addr_k_in = 8'(k);
        bus.sum_in    = 8'(s);
        bus.out_rdy   = rdy;
        @(posedge clk);
        model_edge(v, i, k, s, rdy);
        #1 check_all(tag);
    endtask

    task automatic idle(input string tag, input bit rdy);
        step(tag, 1'b0, 0, 0, 0, rdy);
    endtask

    task automatic row(input string tag, input int i, input int s0, input int s1, input int s2, input int s3,
                       input bit rdy, input bit rdy_last);
        step(tag, 1'b1, i, 0, s0, rdy);
        step(tag, 1'b1, i, 1, s1, rdy);
        step(tag, 1'b1, i, 2, s2, rdy);
        step(tag, 1'b1, i, 3, s3, rdy_last);
    endtask

    // Asserted between edges so that the asynchronous clear can be observed right away.
    task automatic async_reset(input string tag);
        #1;
        bus.val_in = 1'b0;
        reset = 1'b1;
        #1;
        q_addr.delete();
        q_data.delete();
        m_ovf = 1'b0;
        m_bad = 1'b0;
        foreach (nk[r]) nk[r] = 0;
        check_all(tag);
        chk({tag, ":count0"}, 32'(fifo_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bus.val_in = 1'b0; bus.addr_i_in = '0; bus.addr_k_in = '0; bus.sum_in = '0; bus.out_rdy = 1'b0;
        m_ovf = 1'b0; m_bad = 1'b0;
        foreach (acc_m[a]) acc_m[a] = 0;
        foreach (nk[r]) nk[r] = 0;
        reset = 1'b1;
        #1 check_all("por");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Single row, 3+4+5+6
        row("t1", 5, 3, 4, 5, 6, 1'b1, 1'b1);
        chk("t1:out_val", 32'(bus.out_val), 32'd1);
        chk("t1:out_data", 32'(bus.out_data), 32'd18);
        chk("t1:out_addr_i", 32'(bus.out_addr_i), 32'd5);
        idle("t1_after", 1'b1);
        chk("t1:pulse_end", 32'(bus.out_val), 32'd0);

        // Two rows interleaved
        step("t2", 1'b1, 1, 0, 10, 1'b0);
        step("t2", 1'b1, 2, 0, 20, 1'b0);
        for (int k = 1; k < NK; k++) begin
            step("t2", 1'b1, 1, k, 1, 1'b0);
            step("t2", 1'b1, 2, k, 1, 1'b0);
        end
        chk("t2:count", 32'(fifo_count), 32'd2);
        chk("t2:head_addr", 32'(bus.out_addr_i), 32'd1);
        chk("t2:head_data", 32'(bus.out_data), 32'd13);
        idle("t2_drain", 1'b1);
        chk("t2:second_addr", 32'(bus.out_addr_i), 32'd2);
        chk("t2:second_data", 32'(bus.out_data), 32'd23);
        idle("t2_drain", 1'b1);

        // Modulo wrap: 200+100 = 300 -> 44
        row("t3", 0, 200, 100, 0, 0, 1'b0, 1'b0);
        chk("t3:out_data", 32'(bus.out_data), 32'd44);
        chk("t3:err_overflow", 32'(err_overflow), 32'd0);
        chk("t3:err_bad_k", 32'(err_bad_k), 32'd0);
        idle("t3_drain", 1'b1);

        // Backpressure: 5 rows into a 4-deep FIFO
        for (int r = 0; r < 5; r++) begin
            row("t4", 10 + r, r, 1, 1, 1, 1'b0, 1'b0);
            if (r == 1) begin
                chk("t4:count2", 32'(fifo_count), 32'd2);
                chk("t4:afull_at2", 32'(almost_full), 32'd1);
            end
        end
        chk("t4:count_full", 32'(fifo_count), 32'd4);
        chk("t4:overflow", 32'(err_overflow), 32'd1);
        for (int r = 0; r < 4; r++) begin
            chk("t4:drain_addr", 32'(bus.out_addr_i), 32'(10 + r));
            idle("t4_drain", 1'b1);
        end
        chk("t4:empty", 32'(bus.out_val), 32'd0);

        // Full FIFO with a completion and a pop on the same edge
        async_reset("t5_rst");
        for (int r = 0; r < 4; r++) row("t5", 20 + r, 1, 1, 1, r, 1'b0, 1'b0);
        row("t5_last", 24, 2, 2, 2, 2, 1'b0, 1'b1);
        chk("t5:no_overflow", 32'(err_overflow), 32'd0);
        chk("t5:count", 32'(fifo_count), 32'd4);
        for (int r = 0; r < 4; r++) idle("t5_drain", 1'b1);
        chk("t5:empty", 32'(bus.out_val), 32'd0);

        // Illegal K index, then a reset in the middle of a row
        row("t6", 7, 1, 1, 1, 1, 1'b0, 1'b0);
        step("t6_badk", 1'b1, 3, 7, 9, 1'b0);
        chk("t6:bad_k", 32'(err_bad_k), 32'd1);
        chk("t6:no_push", 32'(fifo_count), 32'd1);
        step("t6", 1'b1, 8, 0, 50, 1'b0);
        step("t6", 1'b1, 8, 1, 50, 1'b0);
        async_reset("t6_rst");
        chk("t6:flags_clr", 32'({err_bad_k, err_overflow, almost_full}), 32'd0);
        row("t6_fresh", 8, 1, 2, 3, 4, 1'b1, 1'b1);
        chk("t6:fresh_data", 32'(bus.out_data), 32'd10);
        idle("t6_drain", 1'b1);

        // Random traffic against the model
        async_reset("rnd_rst");
        for (int n = 0; n < 600; n++) begin
            bit v = $urandom_range(0, 9) < 8;
            int rr = $urandom_range(0, 5);
            bit bad = $urandom_range(0, 19) == 0;
            int k = bad ? $urandom_range(NK, 255) : nk[rr];
            bit rdy = $urandom_range(0, 2) != 0;
            if (v && !bad) nk[rr] = (nk[rr] + 1) % NK;
            if (n == 300) async_reset("rnd_mid_rst");
            else step("rnd", v, rr, k, $urandom_range(0, 255), rdy);
        end
        for (int n = 0; n < DEPTH + 1; n++) idle("rnd_drain", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
